// File: rtl/psram_bist_pkg.sv
// rtl/psram_bist_pkg.sv - shared types and constants for the PSRAM BIST engine
//
// Purpose: FSM state encoding, data-pattern mode codes and the seed bytes
// used by the incrementing-byte patterns.
package psram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_W,
    S_WRITE,
    S_WAIT_R,
    S_READ,
    S_NEXT
  } state_t;

  localparam logic [1:0] MODE_INC     = 2'd0;
  localparam logic [1:0] MODE_WALK1   = 2'd1;
  localparam logic [1:0] MODE_INV_INC = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  // Seed bytes for lanes 0..3 (lane 0 in the low byte); repeats for wider beats.
  localparam logic [31:0] SEED_WORD = 32'h0406_0103;

  function automatic logic [7:0] seed_byte(input int lane);
    return SEED_WORD[8*(lane%4) +: 8];
  endfunction

endpackage

// File: rtl/psram_pattern_gen.sv
// rtl/psram_pattern_gen.sv - combinational data pattern for one global beat index
//
// Purpose: maps (mode, global beat index g) to one DW-bit beat of test data.
// Ports:
//   mode  in  2   pattern select (inc-bytes, walking-one, inverted inc-bytes, checkerboard)
//   g     in  32  global beat index within the pass
//   data  out DW  pattern word
module psram_pattern_gen
  import psram_bist_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    mode,
  input  logic [31:0]   g,
  output logic [DW-1:0] data
);

  logic [DW-1:0] inc_bytes;

  always_comb begin
    inc_bytes = '0;
    for (int i = 0; i < DW/8; i++) begin
      inc_bytes[8*i +: 8] = seed_byte(i) + g[7:0];
    end
  end

  always_comb begin
    data = '0;
    case (mode)
      MODE_INC:     data = inc_bytes;
      MODE_WALK1:   data = {{(DW-1){1'b0}}, 1'b1} << (g % 32'(DW));
      MODE_INV_INC: data = ~inc_bytes;
      default:      data = g[0] ? {(DW/2){2'b10}} : {(DW/2){2'b01}};
    endcase
  end

endmodule

// File: rtl/psram_bist_engine.sv
// rtl/psram_bist_engine.sv - PSRAM traffic generator and read-back checker
//
// Purpose: walks NUM_BURSTS address windows, writing one burst of the selected
// pattern and reading it back for comparison; counts passes and mismatches.
// Ports:
//   ram_clk, ram_rst          clock, async active-high reset
//   init_cable_complete       controller calibrated (sampled in IDLE)
//   ctrl_idle                 controller ready for a command
//   cfg_run, cfg_mode         level run enable, pattern mode
//   ram_wr_valid/ram_rd_valid per-beat write accept / read data valid
//   ram_data_out              read data
//   addr_in, rw_ctrl, ram_en  command address, direction (1 = write), strobe
//   ram_data_in               write data
//   pass_cnt, err_cnt, err_flag, first_err_addr   statistics
module psram_bist_engine
  import psram_bist_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int BURST_LEN   = 32,
  parameter int NUM_BURSTS  = 4,
  parameter int ADDR_STRIDE = 64,
  parameter int BASE_ADDR   = 4,
  parameter int WAIT_CYC    = 64,
  parameter int ERR_W       = 16
) (
  input  logic                   ram_clk,
  input  logic                   ram_rst,
  input  logic                   init_cable_complete,
  input  logic                   ctrl_idle,
  input  logic                   cfg_run,
  input  logic [1:0]             cfg_mode,
  input  logic                   ram_wr_valid,
  input  logic                   ram_rd_valid,
  input  logic [2*BIT_WIDTH-1:0] ram_data_out,
  output logic [31:0]            addr_in,
  output logic                   rw_ctrl,
  output logic                   ram_en,
  output logic [2*BIT_WIDTH-1:0] ram_data_in,
  output logic [15:0]            pass_cnt,
  output logic [ERR_W-1:0]       err_cnt,
  output logic                   err_flag,
  output logic [31:0]            first_err_addr
);

  localparam int DW    = 2*BIT_WIDTH;
  localparam int BEATS = BURST_LEN/2;
  localparam int BW    = $clog2(BEATS);
  localparam int NW    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int WW    = $clog2(WAIT_CYC);   // WAIT_CYC must be >= 2

  function automatic logic [DW-1:0] rst_pattern();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < DW/8; i++) d[8*i +: 8] = seed_byte(i);
    return d;
  endfunction

  localparam logic [DW-1:0] RST_DATA = rst_pattern();

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat;
  logic [NW-1:0] burst_idx;
  logic [1:0]    mode_q;
  logic          mis_q;

  logic          enter_ww;
  logic [NW-1:0] nxt_burst;
  logic [1:0]    nxt_mode;
  logic          last_burst, beat_last, wr_acc, rd_acc;
  logic [31:0]   g_cur, wr_g;
  logic [1:0]    wr_mode;
  logic [DW-1:0] wr_data, exp_data;

  assign last_burst = (burst_idx == NW'(NUM_BURSTS-1));
  assign beat_last  = (beat == BW'(BEATS-1));
  assign wr_acc     = (state == S_WRITE) && ram_wr_valid;
  assign rd_acc     = (state == S_READ) && ram_rd_valid;
  assign g_cur      = 32'(burst_idx) * 32'(BEATS) + 32'(beat);

  // Window/mode the FSM will hold after the next edge if it enters WAIT_W;
  // cfg_mode is only picked up here, at pass start or pass wrap.
  always_comb begin
    enter_ww  = 1'b0;
    nxt_burst = burst_idx;
    nxt_mode  = mode_q;
    if (state == S_IDLE && init_cable_complete && cfg_run) begin
      enter_ww  = 1'b1;
      nxt_burst = '0;
      nxt_mode  = cfg_mode;
    end else if (state == S_NEXT) begin
      if (last_burst) begin
        enter_ww  = cfg_run;
        nxt_burst = '0;
        nxt_mode  = cfg_mode;
      end else begin
        enter_ww  = 1'b1;
        nxt_burst = burst_idx + 1'b1;
      end
    end
  end

  // Write generator looks one step ahead: beat 0 of the new window on entry,
  // otherwise the beat following the one being accepted.
  assign wr_mode = enter_ww ? nxt_mode : mode_q;
  assign wr_g    = enter_ww ? 32'(nxt_burst) * 32'(BEATS) : g_cur + 32'd1;

  psram_pattern_gen #(.DW(DW)) u_wr_gen (.mode(wr_mode), .g(wr_g),  .data(wr_data));
  psram_pattern_gen #(.DW(DW)) u_rd_gen (.mode(mode_q),  .g(g_cur), .data(exp_data));

  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      beat           <= '0;
      burst_idx      <= '0;
      mode_q         <= MODE_INC;
      mis_q          <= 1'b0;
      addr_in        <= 32'(BASE_ADDR);
      rw_ctrl        <= 1'b1;
      ram_en         <= 1'b0;
      ram_data_in    <= RST_DATA;
      pass_cnt       <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
    end else begin
      ram_en <= 1'b0;

      // Compare result is registered; stats follow one cycle later, so the
      // last beat of a burst still lands after the FSM has left READ.
      mis_q <= rd_acc && (ram_data_out != exp_data);
      if (mis_q) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (!err_flag) first_err_addr <= addr_in;
        err_flag <= 1'b1;
      end

      if (enter_ww) begin
        burst_idx   <= nxt_burst;
        mode_q      <= nxt_mode;
        addr_in     <= 32'(BASE_ADDR) + 32'(nxt_burst) * 32'(ADDR_STRIDE);
        ram_data_in <= wr_data;
      end

      case (state)
        S_IDLE: begin
          if (enter_ww) begin
            state    <= S_WAIT_W;
            wait_cnt <= '0;
          end
        end
        S_WAIT_W, S_WAIT_R: begin
          if (ram_en) begin
            state    <= (state == S_WAIT_W) ? S_WRITE : S_READ;
            wait_cnt <= '0;
          end else if (!ctrl_idle) begin
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // Strobe rises together with wait_cnt reaching WAIT_CYC-1.
            ram_en   <= (wait_cnt == WW'(WAIT_CYC-2));
          end
        end
        S_WRITE: begin
          if (wr_acc) begin
            ram_data_in <= wr_data;
            beat        <= beat + 1'b1;
            if (beat_last) begin
              beat    <= '0;
              state   <= S_WAIT_R;
              rw_ctrl <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (rd_acc) begin
            beat <= beat + 1'b1;
            if (beat_last) begin
              beat    <= '0;
              state   <= S_NEXT;
              rw_ctrl <= 1'b1;
            end
          end
        end
        S_NEXT: begin
          if (last_burst) pass_cnt <= pass_cnt + 1'b1;
          state    <= enter_ww ? S_WAIT_W : S_IDLE;
          wait_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
